control_unit: RTL and testbench

- Moore FSM that sequences the 8-bit computer's datapath: instruction fetch, decode and execute.
- Drives MAR/PC/IR/A/B/CCR load enables, the bus mux selects, the ALU select, and the `write` strobe into data memory. Data memory covers addresses 128–223 and has a registered read: data appears one clock after MAR is loaded.
- Sits directly upstream of the memory system; its `write` output connects straight to the data memory `write` input.

---
 rtl/computer_pkg.sv | 42 ++++
 rtl/control_unit.sv | 148 ++++++++++++++
 tb/tb_control_unit.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/computer_pkg.sv
// Shared definitions for the 8-bit computer: opcodes, bus/ALU select encodings
// and the control unit state enum.
package computer_pkg;

    localparam logic [7:0] OP_LDA_IMM = 8'h86;
    localparam logic [7:0] OP_LDA_DIR = 8'h87;
    localparam logic [7:0] OP_LDB_IMM = 8'h88;
    localparam logic [7:0] OP_LDB_DIR = 8'h89;
    localparam logic [7:0] OP_STA_DIR = 8'h96;
    localparam logic [7:0] OP_STB_DIR = 8'h97;
    localparam logic [7:0] OP_ADD_AB  = 8'h42;
    localparam logic [7:0] OP_SUB_AB  = 8'h43;
    localparam logic [7:0] OP_BRA     = 8'h20;
    localparam logic [7:0] OP_BEQ     = 8'h23;

    localparam logic [1:0] BUS1_PC  = 2'b00;
    localparam logic [1:0] BUS1_A   = 2'b01;
    localparam logic [1:0] BUS1_B   = 2'b10;

    localparam logic [1:0] BUS2_ALU  = 2'b00;
    localparam logic [1:0] BUS2_BUS1 = 2'b01;
    localparam logic [1:0] BUS2_MEM  = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    localparam int CCR_Z_BIT = 2;

    typedef enum logic [5:0] {
        S_FETCH_0, S_FETCH_1, S_FETCH_2, S_DECODE_3,
        S_LDA_IMM_4, S_LDA_IMM_5, S_LDA_IMM_6,
        S_LDA_DIR_4, S_LDA_DIR_5, S_LDA_DIR_6, S_LDA_DIR_7, S_LDA_DIR_8,
        S_LDB_IMM_4, S_LDB_IMM_5, S_LDB_IMM_6,
        S_LDB_DIR_4, S_LDB_DIR_5, S_LDB_DIR_6, S_LDB_DIR_7, S_LDB_DIR_8,
        S_STA_DIR_4, S_STA_DIR_5, S_STA_DIR_6, S_STA_DIR_7,
        S_STB_DIR_4, S_STB_DIR_5, S_STB_DIR_6, S_STB_DIR_7,
        S_ADD_AB_4, S_SUB_AB_4,
        S_BRA_4, S_BRA_5, S_BRA_6,
        S_BEQ_4, S_BEQ_5, S_BEQ_6, S_BEQ_7
    } state_t;

endpackage

// File: rtl/control_unit.sv
// Moore control FSM for the 8-bit computer: fetch, decode and execute sequencing
// of the datapath load enables, bus selects, ALU select and memory write strobe.
module control_unit
    import computer_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] IR,
    input  logic [3:0] CCR_Result,
    output logic       IR_Load,
    output logic       MAR_Load,
    output logic       PC_Load,
    output logic       PC_Inc,
    output logic       A_Load,
    output logic       B_Load,
    output logic [2:0] ALU_Sel,
    output logic       CCR_Load,
    output logic [1:0] Bus1_Sel,
    output logic [1:0] Bus2_Sel,
    output logic       write
);

    state_t state_q, state_d;

    // Only Z steers the branch; the other flags are don't-care here.
    logic unused_ccr;
    assign unused_ccr = ^{CCR_Result[3], CCR_Result[1:0]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_FETCH_0;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH_0;
        case (state_q)
            S_FETCH_0:  state_d = S_FETCH_1;
            S_FETCH_1:  state_d = S_FETCH_2;
            S_FETCH_2:  state_d = S_DECODE_3;
            S_DECODE_3: begin
                case (IR)
                    OP_LDA_IMM: state_d = S_LDA_IMM_4;
                    OP_LDA_DIR: state_d = S_LDA_DIR_4;
                    OP_LDB_IMM: state_d = S_LDB_IMM_4;
                    OP_LDB_DIR: state_d = S_LDB_DIR_4;
                    OP_STA_DIR: state_d = S_STA_DIR_4;
                    OP_STB_DIR: state_d = S_STB_DIR_4;
                    OP_ADD_AB:  state_d = S_ADD_AB_4;
                    OP_SUB_AB:  state_d = S_SUB_AB_4;
                    OP_BRA:     state_d = S_BRA_4;
                    OP_BEQ:     state_d = CCR_Result[CCR_Z_BIT] ? S_BEQ_4 : S_BEQ_7;
                    default:    state_d = S_FETCH_0;
                endcase
            end
            S_LDA_IMM_4: state_d = S_LDA_IMM_5;
            S_LDA_IMM_5: state_d = S_LDA_IMM_6;
            S_LDA_DIR_4: state_d = S_LDA_DIR_5;
            S_LDA_DIR_5: state_d = S_LDA_DIR_6;
            S_LDA_DIR_6: state_d = S_LDA_DIR_7;
            S_LDA_DIR_7: state_d = S_LDA_DIR_8;
            S_LDB_IMM_4: state_d = S_LDB_IMM_5;
            S_LDB_IMM_5: state_d = S_LDB_IMM_6;
            S_LDB_DIR_4: state_d = S_LDB_DIR_5;
            S_LDB_DIR_5: state_d = S_LDB_DIR_6;
            S_LDB_DIR_6: state_d = S_LDB_DIR_7;
            S_LDB_DIR_7: state_d = S_LDB_DIR_8;
            S_STA_DIR_4: state_d = S_STA_DIR_5;
            S_STA_DIR_5: state_d = S_STA_DIR_6;
            S_STA_DIR_6: state_d = S_STA_DIR_7;
            S_STB_DIR_4: state_d = S_STB_DIR_5;
            S_STB_DIR_5: state_d = S_STB_DIR_6;
            S_STB_DIR_6: state_d = S_STB_DIR_7;
            S_BRA_4:     state_d = S_BRA_5;
            S_BRA_5:     state_d = S_BRA_6;
            S_BEQ_4:     state_d = S_BEQ_5;
            S_BEQ_5:     state_d = S_BEQ_6;
            // Last execute states and illegal encodings fall back to fetch.
            default:     state_d = S_FETCH_0;
        endcase
    end

    // Reset gates the decode so nothing pulses while reset is held.
    always_comb begin
        IR_Load  = 1'b0;
        MAR_Load = 1'b0;
        PC_Load  = 1'b0;
        PC_Inc   = 1'b0;
        A_Load   = 1'b0;
        B_Load   = 1'b0;
        ALU_Sel  = ALU_ADD;
        CCR_Load = 1'b0;
        Bus1_Sel = BUS1_PC;
        Bus2_Sel = BUS2_ALU;
        write    = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH_0, S_LDA_IMM_4, S_LDA_DIR_4, S_LDB_IMM_4, S_LDB_DIR_4,
                S_STA_DIR_4, S_STB_DIR_4, S_BRA_4, S_BEQ_4: begin
                    Bus1_Sel = BUS1_PC;
                    Bus2_Sel = BUS2_BUS1;
                    MAR_Load = 1'b1;
                end
                S_FETCH_1, S_LDA_IMM_5, S_LDA_DIR_5, S_LDB_IMM_5, S_LDB_DIR_5,
                S_STA_DIR_5, S_STB_DIR_5, S_BEQ_7: begin
                    PC_Inc = 1'b1;
                end
                S_FETCH_2: begin
                    Bus2_Sel = BUS2_MEM;
                    IR_Load  = 1'b1;
                end
                S_LDA_IMM_6, S_LDA_DIR_8: begin
                    Bus2_Sel = BUS2_MEM;
                    A_Load   = 1'b1;
                end
                S_LDB_IMM_6, S_LDB_DIR_8: begin
                    Bus2_Sel = BUS2_MEM;
                    B_Load   = 1'b1;
                end
                // Operand byte is the effective address.
                S_LDA_DIR_6, S_LDB_DIR_6, S_STA_DIR_6, S_STB_DIR_6: begin
                    Bus2_Sel = BUS2_MEM;
                    MAR_Load = 1'b1;
                end
                S_STA_DIR_7: begin
                    Bus1_Sel = BUS1_A;
                    write    = 1'b1;
                end
                S_STB_DIR_7: begin
                    Bus1_Sel = BUS1_B;
                    write    = 1'b1;
                end
                S_ADD_AB_4, S_SUB_AB_4: begin
                    Bus1_Sel = BUS1_B;
                    ALU_Sel  = (state_q == S_SUB_AB_4) ? ALU_SUB : ALU_ADD;
                    Bus2_Sel = BUS2_ALU;
                    A_Load   = 1'b1;
                    CCR_Load = 1'b1;
                end
                S_BRA_6, S_BEQ_6: begin
                    Bus2_Sel = BUS2_MEM;
                    PC_Load  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: per-cycle expected output words are queued
// by the stimulus from an instruction-level timing model and popped by a monitor.
module tb_control_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] IR;
    logic [3:0] CCR_Result;
    logic       IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load, write;
    logic [2:0] ALU_Sel;
    logic [1:0] Bus1_Sel, Bus2_Sel;

    control_unit dut (
        .clock(clock), .reset(reset), .IR(IR), .CCR_Result(CCR_Result),
        .IR_Load(IR_Load), .MAR_Load(MAR_Load), .PC_Load(PC_Load), .PC_Inc(PC_Inc),
        .A_Load(A_Load), .B_Load(B_Load), .ALU_Sel(ALU_Sel), .CCR_Load(CCR_Load),
        .Bus1_Sel(Bus1_Sel), .Bus2_Sel(Bus2_Sel), .write(write)
    );

    always #5 clock = ~clock;

    // {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, ALU_Sel, CCR_Load, Bus1, Bus2, write}
    typedef logic [14:0] ov_t;
    ov_t outs;
    assign outs = {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, ALU_Sel,
                   CCR_Load, Bus1_Sel, Bus2_Sel, write};

    int   tests = 0;
    int   fails = 0;
    ov_t  exp_q[$];
    string tag_q[$];

    task automatic check(input string name, input ov_t act, input ov_t want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    function automatic ov_t mk(input bit ir_ld, input bit mar_ld, input bit pc_ld,
                               input bit pc_inc, input bit a_ld, input bit b_ld,
                               input logic [2:0] alu, input bit ccr_ld,
                               input logic [1:0] b1, input logic [1:0] b2, input bit wr);
        return {ir_ld, mar_ld, pc_ld, pc_inc, a_ld, b_ld, alu, ccr_ld, b1, b2, wr};
    endfunction

    // Micro-operation vocabulary of the machine, named by what the datapath does.
    function automatic ov_t mar_from_pc();  return mk(0,1,0,0,0,0,3'd0,0,2'b00,2'b01,0); endfunction
    function automatic ov_t mar_from_mem(); return mk(0,1,0,0,0,0,3'd0,0,2'b00,2'b10,0); endfunction
    function automatic ov_t pc_inc();       return mk(0,0,0,1,0,0,3'd0,0,2'b00,2'b00,0); endfunction
    function automatic ov_t idle();         return '0; endfunction
    function automatic ov_t ir_from_mem();  return mk(1,0,0,0,0,0,3'd0,0,2'b00,2'b10,0); endfunction
    function automatic ov_t a_from_mem();   return mk(0,0,0,0,1,0,3'd0,0,2'b00,2'b10,0); endfunction
    function automatic ov_t b_from_mem();   return mk(0,0,0,0,0,1,3'd0,0,2'b00,2'b10,0); endfunction
    function automatic ov_t pc_from_mem();  return mk(0,0,1,0,0,0,3'd0,0,2'b00,2'b10,0); endfunction
    function automatic ov_t store(input logic [1:0] src);
        return mk(0,0,0,0,0,0,3'd0,0,src,2'b00,1);
    endfunction
    function automatic ov_t alu_op(input logic [2:0] sel);
        return mk(0,0,0,0,1,0,sel,1,2'b10,2'b00,0);
    endfunction

    // Cycle-by-cycle datapath activity for one instruction, from fetch to return.
    task automatic model(input logic [7:0] op, input logic [3:0] ccr, output ov_t seq[$]);
        seq = {};
        seq.push_back(mar_from_pc());
        seq.push_back(pc_inc());
        seq.push_back(ir_from_mem());
        seq.push_back(idle());
        case (op)
            8'h86, 8'h88: begin
                seq.push_back(mar_from_pc()); seq.push_back(pc_inc());
                seq.push_back(op == 8'h86 ? a_from_mem() : b_from_mem());
            end
            8'h87, 8'h89: begin
                seq.push_back(mar_from_pc()); seq.push_back(pc_inc());
                seq.push_back(mar_from_mem()); seq.push_back(idle());
                seq.push_back(op == 8'h87 ? a_from_mem() : b_from_mem());
            end
            8'h96, 8'h97: begin
                seq.push_back(mar_from_pc()); seq.push_back(pc_inc());
                seq.push_back(mar_from_mem());
                seq.push_back(store(op == 8'h96 ? 2'b01 : 2'b10));
            end
            8'h42: seq.push_back(alu_op(3'b000));
            8'h43: seq.push_back(alu_op(3'b001));
            8'h20: begin
                seq.push_back(mar_from_pc()); seq.push_back(idle()); seq.push_back(pc_from_mem());
            end
            8'h23: begin
                if (ccr[2]) begin
                    seq.push_back(mar_from_pc()); seq.push_back(idle()); seq.push_back(pc_from_mem());
                end else begin
                    seq.push_back(pc_inc());
                end
            end
            default: ;
        endcase
    endtask

    // Called at posedge+1 with the DUT in FETCH_0. cut>0 pulses reset after cut cycles.
    task automatic run_instr(input logic [7:0] op, input logic [3:0] ccr, input int cut);
        ov_t seq[$];
        int  n;
        model(op, ccr, seq);
        n = (cut > 0 && cut < seq.size()) ? cut : seq.size();
        IR = op;
        CCR_Result = ccr;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(seq[i]);
            tag_q.push_back($sformatf("op%02h_c%0d", op, i + 1));
        end
        repeat (n) begin @(posedge clock); #1; end
        if (cut > 0) begin
            reset = 1'b1;
            #1 check($sformatf("async_reset_op%02h", op), outs, '0);
            repeat (2) begin exp_q.push_back('0); tag_q.push_back("held_reset"); end
            @(posedge clock); #1;
            @(posedge clock); #1;
            reset = 1'b0;
        end
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) check(tag_q.pop_front(), outs, exp_q.pop_front());
    end

    localparam int NOPS = 10;
    logic [7:0] ops [NOPS] = '{8'h86, 8'h87, 8'h88, 8'h89, 8'h96, 8'h97,
                               8'h42, 8'h43, 8'h20, 8'h23};

    initial begin
        reset = 1'b1;
        IR = 8'h00;
        CCR_Result = 4'h0;
        #12 check("reset_outputs", outs, '0);
        @(posedge clock); #1;
        reset = 1'b0;
        #1 check("release_fetch0", outs, mar_from_pc());

        run_instr(8'h86, 4'b0000, 0);
        run_instr(8'h96, 4'b0000, 0);
        run_instr(8'h23, 4'b0100, 0);
        run_instr(8'h23, 4'b0000, 0);
        run_instr(8'h43, 4'b0000, 0);
        run_instr(8'hFF, 4'b0100, 0);
        run_instr(8'h42, 4'b1111, 0);
        run_instr(8'h96, 4'b0000, 6);
        run_instr(8'h87, 4'b0000, 5);
        run_instr(8'h97, 4'b0000, 0);

        for (int k = 0; k < 60; k++) begin
            logic [7:0] op;
            op = ($urandom_range(0, 3) != 0) ? ops[$urandom_range(0, NOPS - 1)]
                                            : 8'($urandom);
            run_instr(op, 4'($urandom), (k % 15 == 7) ? int'($urandom_range(1, 6)) : 0);
        end

        @(negedge clock); #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
